// File: rtl/snake_pkg.sv
// Shared snake-game constants: heading encodings, PS/2 set-2 scan codes for
// the arrow keys and WASD, and the state encodings of the keyboard front end.
// The snake update logic imports the same direction and scan-code constants.
package snake_pkg;

    // Heading encodings. Opposite headings differ only in bit 1.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Arrow keys (only meaningful after an E0 prefix)
    localparam logic [7:0] SC_ARR_UP    = 8'h75;
    localparam logic [7:0] SC_ARR_RIGHT = 8'h74;
    localparam logic [7:0] SC_ARR_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;

    // WASD (plain codes)
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {PF_NORM, PF_EXT, PF_BRK, PF_EXT_BRK} pfx_state_t;

    // Heading the snake would reverse into.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw keyboard lines, glitch-filters
// the keyboard clock, deframes start/8 data/odd parity/stop and aborts a
// stalled frame after TIMEOUT_CYCLES.
//   clk, rst           system clock, async active-high reset
//   ps2_clk, ps2_data  raw asynchronous keyboard lines
//   scan_code          data byte of the last good frame
//   scan_valid         1-cycle pulse when scan_code is loaded
//   frame_err          1-cycle pulse on start/parity/stop error or timeout
module ps2_frame_rx
    import snake_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          sample;
    logic          bit_in;

    rx_state_t     state, state_n;
    logic [2:0]    bcnt, bcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0]    code_n;
    logic          valid_n, err_n;

    assign bit_in = dat_sync[1];

    // Synchronizers and clock filter. The filtered clock follows the
    // synchronized one only after FILTER_LEN consecutive differing samples;
    // sample fires in the same cycle the filtered clock falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            fcnt     <= '0;
            sample   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            sample   <= 1'b0;
            if (clk_sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt   <= clk_sync[1];
                fcnt   <= '0;
                sample <= ~clk_sync[1];
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            bcnt       <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            tmo        <= tmo_n;
            scan_code  <= code_n;
            scan_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        par_n   = par;
        code_n  = scan_code;
        valid_n = 1'b0;
        err_n   = 1'b0;
        tmo_n   = (state == RX_IDLE) ? '0 : tmo + 1'b1;

        if (sample) begin
            tmo_n = '0;
            case (state)
                RX_IDLE: begin
                    // A high "start" bit is line noise, not an error.
                    if (!bit_in) begin
                        state_n = RX_DATA;
                        bcnt_n  = '0;
                    end
                end
                RX_DATA: begin
                    shreg_n = {bit_in, shreg[7:1]};
                    bcnt_n  = bcnt + 1'b1;
                    if (bcnt == 3'd7) state_n = RX_PARITY;
                end
                RX_PARITY: begin
                    par_n   = bit_in;
                    state_n = RX_STOP;
                end
                RX_STOP: begin
                    if (bit_in && (^{shreg, par})) begin
                        code_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = RX_IDLE;
                end
                default: state_n = RX_IDLE;
            endcase
        end else if (state != RX_IDLE && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = RX_IDLE;
            tmo_n   = '0;
            err_n   = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Keyboard-to-heading front end for the snake game. Receives PS/2 frames,
// tracks E0/F0 prefixes, maps arrow/WASD make codes to a heading and
// refuses 180-degree reversals.
//   clk, rst           system clock, async active-high reset
//   ps2_clk, ps2_data  raw asynchronous keyboard lines
//   scan_code          last good byte received
//   scan_valid         1-cycle pulse per good byte
//   frame_err          1-cycle pulse per bad or timed-out frame
//   dir                heading: 00 up, 01 right, 10 down, 11 left
//   dir_valid          1-cycle pulse when dir changes
module ps2_direction_decoder
    import snake_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic [1:0] dir,
    output logic       dir_valid
);

    pfx_state_t pstate, pstate_n;
    logic       req_ok;
    logic [1:0] req_dir;
    logic       accept;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pstate <= PF_NORM;
        else     pstate <= pstate_n;
    end

    // Prefix tracking and make-code mapping. Only scan_valid advances the
    // decoder, so an errored frame leaves a pending E0/F0 in place.
    always_comb begin
        pstate_n = pstate;
        req_ok   = 1'b0;
        req_dir  = dir;
        if (scan_valid) begin
            case (pstate)
                PF_NORM: begin
                    if (scan_code == SC_EXT)      pstate_n = PF_EXT;
                    else if (scan_code == SC_BRK) pstate_n = PF_BRK;
                    else begin
                        pstate_n = PF_NORM;
                        req_ok   = 1'b1;
                        case (scan_code)
                            SC_W:    req_dir = DIR_UP;
                            SC_D:    req_dir = DIR_RIGHT;
                            SC_S:    req_dir = DIR_DOWN;
                            SC_A:    req_dir = DIR_LEFT;
                            default: req_ok  = 1'b0;
                        endcase
                    end
                end
                PF_EXT: begin
                    if (scan_code == SC_BRK) pstate_n = PF_EXT_BRK;
                    else begin
                        pstate_n = PF_NORM;
                        req_ok   = 1'b1;
                        case (scan_code)
                            SC_ARR_UP:    req_dir = DIR_UP;
                            SC_ARR_RIGHT: req_dir = DIR_RIGHT;
                            SC_ARR_DOWN:  req_dir = DIR_DOWN;
                            SC_ARR_LEFT:  req_dir = DIR_LEFT;
                            default:      req_ok  = 1'b0;
                        endcase
                    end
                end
                // Byte after F0 is a key release; swallow it.
                default: pstate_n = PF_NORM;
            endcase
        end
    end

    assign accept = req_ok && (req_dir != dir) && (req_dir != dir_opposite(dir));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir       <= DIR_RIGHT;
            dir_valid <= 1'b0;
        end else begin
            dir_valid <= accept;
            if (accept) dir <= req_dir;
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
module tb_ps2_direction_decoder;

    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err, dir_valid;
    logic [1:0] dir;

    int nchecks = 0;
    int nfail   = 0;
    int sv_cnt = 0, fe_cnt = 0, dv_cnt = 0;
    logic sv_prev = 1'b0;

    typedef struct {
        logic [7:0] code;
        logic [1:0] exp_dir;
        int         exp_dv;
    } vec_t;
    vec_t vecs[14];

    ps2_direction_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err),
        .dir        (dir),
        .dir_valid  (dir_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters and cycle-level invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (scan_valid) sv_cnt++;
            if (frame_err)  fe_cnt++;
            if (dir_valid) begin
                dv_cnt++;
                check("dir_valid_follows_scan_valid", int'(sv_prev), 1);
            end
            if (scan_valid || frame_err)
                check("scan_valid_and_frame_err_exclusive", int'(scan_valid & frame_err), 0);
        end
        sv_prev = scan_valid;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clr_cnt();
        @(posedge clk);
        sv_cnt = 0; fe_cnt = 0; dv_cnt = 0;
    endtask

    // One PS/2 bit: data set up in the high phase, sampled on the fall.
    // Optional 1-cycle glitches in both phases of the keyboard clock.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        wait_clk(10);
        if (glitch) begin ps2_clk = 1'b0; wait_clk(1); ps2_clk = 1'b1; wait_clk(9); end
        else wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(20);
        if (glitch) begin ps2_clk = 1'b1; wait_clk(1); ps2_clk = 1'b0; wait_clk(19); end
        else wait_clk(20);
        ps2_clk = 1'b1;
        wait_clk(20);
    endtask

    task automatic send_bits(input logic [7:0] code, input bit flip_par,
                             input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^code) ^ flip_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i], glitch);
        ps2_data = 1'b1;
    endtask

    task automatic send_code(input logic [7:0] code, input bit flip_par = 1'b0,
                             input bit glitch = 1'b0);
        send_bits(code, flip_par, 11, glitch);
        wait_clk(30);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        sv_cnt = 0; fe_cnt = 0; dv_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_scan_code"}, scan_code, 8'h00);
        check({tag, "_scan_valid"}, scan_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_dir"}, dir, 2'b01);
        check({tag, "_dir_valid"}, dir_valid, 0);
    endtask

    initial begin
        vecs[0]  = '{8'h1D, 2'b00, 1};  // W: up
        vecs[1]  = '{8'h1B, 2'b00, 0};  // S: reversal rejected
        vecs[2]  = '{8'h1C, 2'b11, 1};  // A: left
        vecs[3]  = '{8'h23, 2'b11, 0};  // D: reversal rejected
        vecs[4]  = '{8'h1C, 2'b11, 0};  // A again: no change
        vecs[5]  = '{8'hE0, 2'b11, 0};  // prefix
        vecs[6]  = '{8'h75, 2'b00, 1};  // ext up
        vecs[7]  = '{8'hE0, 2'b00, 0};
        vecs[8]  = '{8'h72, 2'b00, 0};  // ext down: reversal
        vecs[9]  = '{8'hF0, 2'b00, 0};  // break prefix
        vecs[10] = '{8'h1C, 2'b00, 0};  // break of A ignored
        vecs[11] = '{8'h23, 2'b01, 1};  // D: right
        vecs[12] = '{8'h12, 2'b01, 0};  // unmapped
        vecs[13] = '{8'h75, 2'b01, 0};  // 75 without E0: unmapped

        // Reset state, checked while reset is held and after release.
        wait_clk(3);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b0;
        wait_clk(5);
        #1;
        check_reset_outputs("after_release");
        sv_cnt = 0; fe_cnt = 0; dv_cnt = 0;

        // Table-driven single frames from the reset heading.
        for (int i = 0; i < 14; i++) begin
            clr_cnt();
            send_code(vecs[i].code);
            check($sformatf("vec%0d_scan_code", i), scan_code, vecs[i].code);
            check($sformatf("vec%0d_scan_valid_cnt", i), sv_cnt, 1);
            check($sformatf("vec%0d_frame_err_cnt", i), fe_cnt, 0);
            check($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
            check($sformatf("vec%0d_dir_valid_cnt", i), dv_cnt, vecs[i].exp_dv);
        end

        // E0 6B from reset: left is the reverse of right.
        do_reset();
        send_code(8'hE0);
        send_code(8'h6B);
        check("ext_left_rev_dir", dir, 2'b01);
        check("ext_left_rev_dv", dv_cnt, 0);

        // E0 72 then E0 F0 72.
        clr_cnt();
        send_code(8'hE0);
        send_code(8'h72);
        check("ext_down_dir", dir, 2'b10);
        check("ext_down_dv", dv_cnt, 1);
        clr_cnt();
        send_code(8'hE0);
        send_code(8'hF0);
        send_code(8'h72);
        check("ext_break_sv", sv_cnt, 3);
        check("ext_break_dv", dv_cnt, 0);
        check("ext_break_dir", dir, 2'b10);

        // Bad parity.
        clr_cnt();
        send_code(8'h23, 1'b1);
        check("parity_err_cnt", fe_cnt, 1);
        check("parity_sv_cnt", sv_cnt, 0);
        check("parity_scan_code", scan_code, 8'h72);
        check("parity_dir", dir, 2'b10);

        // Partial frame then timeout, then a good frame.
        clr_cnt();
        send_bits(8'h1B, 1'b0, 4, 1'b0);
        wait_clk(TMO + 100);
        check("timeout_err_cnt", fe_cnt, 1);
        check("timeout_sv_cnt", sv_cnt, 0);
        clr_cnt();
        send_code(8'h1B);
        check("after_timeout_scan_code", scan_code, 8'h1B);
        check("after_timeout_sv_cnt", sv_cnt, 1);
        check("after_timeout_err_cnt", fe_cnt, 0);

        // Pending E0 survives an errored frame.
        clr_cnt();
        send_code(8'hE0);
        send_code(8'h44, 1'b1);
        send_code(8'h6B);
        check("prefix_keep_err_cnt", fe_cnt, 1);
        check("prefix_keep_dir", dir, 2'b11);
        check("prefix_keep_dv", dv_cnt, 1);

        // Glitchy keyboard clock.
        clr_cnt();
        send_code(8'h1C, 1'b0, 1'b1);
        check("glitch_scan_code", scan_code, 8'h1C);
        check("glitch_sv_cnt", sv_cnt, 1);
        check("glitch_err_cnt", fe_cnt, 0);

        // Reset in the middle of a frame.
        clr_cnt();
        send_bits(8'h1D, 1'b0, 5, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        #1;
        check_reset_outputs("midframe_release");
        sv_cnt = 0; fe_cnt = 0; dv_cnt = 0;
        send_code(8'h1D);
        check("post_rst_scan_code", scan_code, 8'h1D);
        check("post_rst_err_cnt", fe_cnt, 0);
        check("post_rst_dir", dir, 2'b00);
        check("post_rst_dv", dv_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/ps2_direction_decoder.md
# ps2_direction_decoder

Receives PS/2 keyboard frames and turns arrow/WASD make codes into a registered snake heading for the game logic. It sits between the keyboard pins and the snake position/update logic. It runs in the same `clk` domain as the VGA controller and renderer. It deframes the PS/2 serial stream and tracks E0/F0 prefixes. It also rejects 180° reversals so the snake cannot turn into itself.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical `clk` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles mid-frame before the partial frame is aborted.

Ports:
- `clk` in 1: system clock. Everything is in this domain.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw keyboard clock, asynchronous.
- `ps2_data` in 1: raw keyboard data, asynchronous.
- `scan_code` out 8: last good frame's data byte. Reset value 8'h00.
- `scan_valid` out 1: one-cycle pulse when `scan_code` updates. Reset value 0.
- `frame_err` out 1: one-cycle pulse on a start, parity, or stop error, or on a timeout. Reset value 0.
- `dir` out 2: current heading. 00 up, 01 right, 10 down, 11 left. Reset value 01 (right).
- `dir_valid` out 1: one-cycle pulse when `dir` changes value. Reset value 0.

## Operation
- **Input conditioning:** two-flop synchronizer on both `ps2_clk` and `ps2_data`. The synchronized `ps2_clk` then passes through a glitch filter: it flips only after `FILTER_LEN` equal samples. A falling edge of the filtered clock is a sample event.
- **Frame FSM:** states IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample event with data=0 (start bit), go to DATA with bit count 0. A sample event with data=1 stays in IDLE and raises no error.
  - DATA: shift in 8 bits, LSB first. Move to PARITY after the 8th bit.
  - PARITY: check odd parity over the 8 data bits plus the parity bit.
  - STOP: require data=1. If parity and stop are both good, load `scan_code` and pulse `scan_valid`. Otherwise pulse `frame_err` and leave `scan_code` unchanged. Return to IDLE in either case.
- **Timeout:** the counter clears on every sample event and counts only outside IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE and pulses `frame_err`.
- **Prefix decoder:** states NORM, EXT, BRK, EXT_BRK. It advances only on `scan_valid`.
  - From NORM: E0 goes to EXT, F0 goes to BRK. Any other code is a make code and returns to NORM.
  - From EXT: F0 goes to EXT_BRK. Any other code is an extended make code and returns to NORM.
  - BRK and EXT_BRK: the next code is a break code. It is ignored and the decoder returns to NORM.
- **Direction mapping (make codes only):**
  - Extended: 75 up, 74 right, 72 down, 6B left.
  - Plain: 1D (W) up, 23 (D) right, 1B (S) down, 1C (A) left.
  - Any other make code is ignored.
- **Reversal rule:** a requested direction equal to `dir` XOR 2'b10 is rejected. A request equal to the current `dir` leaves `dir` unchanged and does not pulse `dir_valid`.

## Timing
- Sample event: 2 synchronizer cycles plus `FILTER_LEN` cycles after the raw falling edge.
- `scan_valid` and `scan_code` update in the `clk` cycle after the stop-bit sample event.
- `dir` and `dir_valid` update exactly one cycle after the `scan_valid` that carries the accepted make code (registered decoder stage).
- A `frame_err` frame does not advance the prefix decoder. A pending E0 or F0 state is kept across the error.
- `rst` asserted at any time, including mid-frame, clears all state to the reset values within the same cycle. No pulse is emitted on reset release.
- `scan_valid` and `frame_err` are never both high in the same cycle.

## Structure
- **Shared package `snake_pkg`:**
  - direction encodings DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT;
  - scan-code constants for E0, F0, the arrow keys and WASD;
  - these constants are reused by the snake update logic.
- **Sub-module `ps2_frame_rx`:** synchronizer, filter, frame FSM and timeout. Outputs `scan_code`, `scan_valid`, `frame_err`.
- **Top level:** instantiates `ps2_frame_rx` and holds the prefix decoder and direction register.

## Test plan
- Reset then one good frame 0x1D (W): `scan_code`=1D with one `scan_valid` pulse. `dir` goes 01→00 one cycle later with one `dir_valid` pulse.
- From reset, send E0 6B (left) while `dir`=01: reversal rejected, `dir` stays 01, no `dir_valid`.
- Send E0 72 (down), then E0 F0 72: `dir`=10 after the make. The break sequence produces 3 `scan_valid` pulses and no `dir` change.
- Frame 0x23 with a flipped parity bit: exactly one `frame_err`, no `scan_valid`, `scan_code` unchanged.
- Send only the start bit plus 3 data bits, then stay idle for `TIMEOUT_CYCLES`: one `frame_err`. A following good 0x1B frame is received correctly.
- 1-cycle glitches on `ps2_clk` during a 0x1C frame (with `FILTER_LEN`=8): no extra bits are captured and `scan_code`=1C. `rst` pulsed mid-frame: all outputs return to reset values.
